// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants, opcode encoding, the operand bundle type
//                and a one-hot helper for the operand-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int RIDX_W = 3;
  localparam int OPC_W  = 4;

  // Full 4-bit opcode space, so any decoded value maps onto a legal member
  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_LI   = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_JMP  = 4'hD,
    OP_MOV  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Operand bundle handed to the execute stage
  typedef struct packed {
    opcode_e             opcode;
    logic [RIDX_W-1:0]   rd;
    logic                writes_rd;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   imm;
  } bundle_t;

  // Register index to one-hot register mask
  function automatic logic [NREG-1:0] onehot(input logic [RIDX_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Busy-register scoreboard. Tracks registers with a pending
//                writeback and flags RAW/WAW hazards for the instruction
//                currently offered to the operand-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_load_i,
  input  logic [RIDX_W-1:0] wb_rd_i,
  input  logic              use_rs1_i,
  input  logic [RIDX_W-1:0] rs1_i,
  input  logic              use_rs2_i,
  input  logic [RIDX_W-1:0] rs2_i,
  input  logic              writes_rd_i,
  input  logic [RIDX_W-1:0] rd_i,
  input  logic              accept_i,
  output logic              hazard_o,
  output logic [NREG-1:0]   busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] eff_busy;

  // A writeback this cycle lands in the bank on the falling edge, so its
  // register is already readable at the next rising edge: treat it as free.
  assign clr      = wb_load_i ? onehot(wb_rd_i) : '0;
  assign eff_busy = busy_q & ~clr;

  // Lookups use state before this instruction's own set, so rd == rs1 is not
  // a self-hazard.
  assign hazard_o = (use_rs1_i   & eff_busy[rs1_i]) |
                    (use_rs2_i   & eff_busy[rs2_i]) |
                    (writes_rd_i & eff_busy[rd_i]);

  // Set is applied after clear so a same-index set/clear leaves the bit busy.
  assign set    = (accept_i & writes_rd_i) ? onehot(rd_i) : '0;
  assign busy_d = eff_busy | set;

  // Scoreboard state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Decode-to-execute operand stage. Accepts one decoded
//                instruction per handshake, selects source operands from the
//                register bank's parallel read outputs, stalls on hazards
//                against pending writebacks and registers the operand bundle
//                toward the ALU with valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_writes_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] reg_q0,
  input  logic [DATA_W-1:0] reg_q1,
  input  logic [DATA_W-1:0] reg_q2,
  input  logic [DATA_W-1:0] reg_q3,
  input  logic [DATA_W-1:0] reg_q4,
  input  logic [DATA_W-1:0] reg_q5,
  input  logic [DATA_W-1:0] reg_q6,
  input  logic [DATA_W-1:0] reg_q7,
  input  logic              wb_load,
  input  logic [RIDX_W-1:0] wb_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_writes_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [NREG-1:0]   busy_vec
);

  logic [DATA_W-1:0] bank_rd [NREG];
  logic              hazard;
  logic              accept;
  logic              out_valid_q;
  bundle_t           out_q;
  bundle_t           out_d;

  assign bank_rd[0] = reg_q0;
  assign bank_rd[1] = reg_q1;
  assign bank_rd[2] = reg_q2;
  assign bank_rd[3] = reg_q3;
  assign bank_rd[4] = reg_q4;
  assign bank_rd[5] = reg_q5;
  assign bank_rd[6] = reg_q6;
  assign bank_rd[7] = reg_q7;

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wb_load_i   (wb_load),
    .wb_rd_i     (wb_rd),
    .use_rs1_i   (in_use_rs1),
    .rs1_i       (in_rs1),
    .use_rs2_i   (in_use_rs2),
    .rs2_i       (in_rs2),
    .writes_rd_i (in_writes_rd),
    .rd_i        (in_rd),
    .accept_i    (accept),
    .hazard_o    (hazard),
    .busy_vec_o  (busy_vec)
  );

  // Ready is independent of in_valid: only hazards and a stuck output block it
  assign in_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Next bundle: load selected operands on accept, otherwise hold
  always_comb begin
    out_d = out_q;
    if (accept) begin
      out_d.opcode    = opcode_e'(in_opcode);
      out_d.rd        = in_rd;
      out_d.writes_rd = in_writes_rd;
      out_d.a         = in_use_rs1 ? bank_rd[in_rs1] : '0;
      out_d.b         = in_use_rs2 ? bank_rd[in_rs2] : '0;
      out_d.imm       = in_imm;
    end
  end

  // Output register and valid tracking; reset drops any in-flight bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      if (accept) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = out_q.opcode;
  assign out_rd        = out_q.rd;
  assign out_writes_rd = out_q.writes_rd;
  assign out_a         = out_q.a;
  assign out_b         = out_q.b;
  assign out_imm       = out_q.imm;

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute operand stage downstream of the 8x16 register bank.
- Takes one decoded instruction per handshake and selects source operands from the bank's eight parallel read outputs.
- Holds a busy-register scoreboard that stalls on RAW/WAW hazards against pending writebacks, then registers the operands toward the ALU with valid/ready flow control.

Parameters:
DATA_W, 16, register/operand width
NREG, 8, number of architectural registers
RIDX_W, 3, register index width (log2 NREG)
OPC_W, 4, opcode field width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_opcode  in  OPC_W  opcode, passed through
in_rd  in  RIDX_W  destination register index
in_rs1  in  RIDX_W  source A index
in_rs2  in  RIDX_W  source B index
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_writes_rd  in  1  instruction will write rd
in_imm  in  DATA_W  immediate, passed through
reg_q0..reg_q7  in  DATA_W each  register bank read outputs (R0..R7)
wb_load  in  1  writeback strobe (same signal driving bank registerLoad)
wb_rd  in  RIDX_W  writeback destination (same as bank rd)
out_valid  out  1  operand bundle valid
out_ready  in  1  execute stage accepts bundle
out_opcode  out  OPC_W  registered opcode
out_rd  out  RIDX_W  registered destination
out_writes_rd  out  1  registered write flag
out_a  out  DATA_W  operand A (rs1 value, 0 if !use_rs1)
out_b  out  DATA_W  operand B (rs2 value, 0 if !use_rs2)
out_imm  out  DATA_W  registered immediate
busy_vec  out  NREG  scoreboard state, bit i = Ri pending write

Behaviour:
- Reset (rst=1 at rising clk): busy_vec=0, out_valid=0, all out_* data fields=0; in_ready combinationally follows the equations below.
- Effective busy: eff_busy = busy_vec & ~(wb_load ? onehot(wb_rd) : 0). The bank writes on the falling edge of the cycle with wb_load, so the new value is on reg_qN before the next rising edge. Clearing in the same cycle is therefore safe (writeback bypass through the bank).
- hazard = (in_use_rs1 & eff_busy[in_rs1]) | (in_use_rs2 & eff_busy[in_rs2]) | (in_writes_rd & eff_busy[in_rd]).
- in_ready = ~hazard & (~out_valid | out_ready). This is combinational, with no dependence on in_valid.
- accept = in_valid & in_ready.
- On accept at edge N: out_* load the selected reg_q[rs1]/reg_q[rs2] (or 0), opcode, rd, imm and writes_rd, and out_valid=1 visible in cycle N+1. Latency is 1 cycle and throughput is 1 per cycle when there is no hazard and out_ready=1.
- No accept and out_ready=1: out_valid clears. Data fields hold their last value.
- out_valid=1 and out_ready=0: all out_* hold stable and in_ready=0 (back-pressure).
- Scoreboard next state: busy_next = (busy_vec & ~clr) | set.
  - clr = wb_load ? onehot(wb_rd) : 0.
  - set = (accept & in_writes_rd) ? onehot(in_rd) : 0.
  - Set and clear on the same index in the same cycle: set wins.
- wb_load to a non-busy register: clear is a no-op, no error.
- in_rs1 == in_rs2: both operands take the same value.
- rd == rs1 in the same instruction: no self-hazard. The hazard check uses pre-set state.
- rst asserted mid-stall or mid-back-pressure: everything returns to reset state next edge and any in-flight bundle is dropped. The writeback source must also be flushed.
- in_valid=0: no state change except clears and output drain.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, NREG, RIDX_W, OPC_W constants.
  - Opcode enumeration.
  - Operand bundle typedef: opcode, rd, writes_rd, a, b, imm.
- One sub-module, reg_scoreboard: busy_vec register plus eff_busy/set/clear logic and the three hazard lookups.
- The 8:1 operand muxes and the output register stay in operand_fetch.

Test Plan:
- Reset, then one instruction with regs R1=0x1234, R2=0x00FF, rs1=1, rs2=2, rd=3, writes_rd=1, out_ready=1 -> next cycle out_valid=1, out_a=0x1234, out_b=0x00FF, busy_vec=0x08.
- Issue write to R3, then issue rs1=3 with no writeback -> in_ready=0 held. Pulse wb_load with wb_rd=3 and bank R3=0xBEEF -> accepted the same cycle, out_a=0xBEEF next cycle, busy_vec bit3 cleared.
- WAW: pending R5, new instruction rd=5 -> stalls until wb_rd=5. The same cycle wb clears and accept sets bit5 -> busy_vec bit5 stays 1.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0. Release -> next instruction accepted, no bundle lost or duplicated.
- Back-to-back independent instructions with out_ready=1 -> one bundle per cycle, correct opcodes in order.
- rst asserted while stalled with busy_vec=0xA4 and out_valid=1 -> after edge busy_vec=0, out_valid=0, out_a=0.
